// File: rtl/spi_master_data_path_if.sv
// Host-side request/response bundle for the SPI initiator: frame request in, status and read data out.
interface spi_master_data_path_if;
  logic        start;
  logic [1:0]  spi_mode;
  logic [19:0] addr_in;
  logic [3:0]  status_in;
  logic [15:0] wdata_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata_out;

  modport master (
    output start, spi_mode, addr_in, status_in, wdata_in,
    input  busy, done, err, rdata_out
  );

  modport slave (
    input  start, spi_mode, addr_in, status_in, wdata_in,
    output busy, done, err, rdata_out
  );
endinterface

// File: rtl/spi_master_data_path.sv
// SPI initiator for 48-bit frames (addr/status/dummy/data, LSB first) on 1/2/4 lanes.
// start-to-done = 1 + DIV_HALF*(2*48/W + 4) clocks; start is ignored while busy, no queueing.
module spi_master_data_path #(
  parameter int DIV_HALF = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  spi_master_data_path_if.slave  host,
  input  logic [3:0]             miso,
  output logic                   sclk,
  output logic                   cs_n,
  output logic [3:0]             mosi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_HI,
    S_SHIFT_LO,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [8:0] LP_PHASE_LAST = 9'(DIV_HALF - 1);
  localparam logic [8:0] LP_GAP_LAST   = 9'(2 * DIV_HALF - 1);

  state_t      r_state;
  logic [8:0]  r_cnt;
  logic [5:0]  r_bit;
  logic [2:0]  r_lanes;
  logic        r_write;
  logic [47:0] r_frame;
  logic [15:0] r_shadow;
  logic [15:0] r_rdata;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_sclk;
  logic        r_cs_n;
  logic [3:0]  r_mosi;

  logic [47:0] w_frame_in;
  logic [2:0]  w_lanes_in;
  logic [15:0] w_shadow_nxt;
  logic [5:0]  w_bit_nxt;

  function automatic logic [3:0] slot_bits(input logic [47:0] f,
                                           input logic [5:0]  b,
                                           input logic [2:0]  w);
    logic [47:0] s;
    logic [3:0]  m;
    s = f >> b;
    case (w)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return s[3:0] & m;
  endfunction

  assign w_frame_in = {host.status_in[2] ? host.wdata_in : 16'h0000, 8'h00,
                       host.status_in, host.addr_in};

  always_comb begin
    w_lanes_in = 3'd4;
    case (host.spi_mode)
      2'b01:   w_lanes_in = 3'd1;
      2'b10:   w_lanes_in = 3'd2;
      default: w_lanes_in = 3'd4;
    endcase
  end

  assign w_bit_nxt = r_bit + {3'b000, r_lanes};

  // Data slots start at bit 32, so the low nibble of the pointer is the read-data index.
  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(r_lanes)) begin
        w_shadow_nxt[4'(r_bit[3:0] + 4'(k))] = miso[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_lanes  <= '0;
      r_write  <= 1'b0;
      r_frame  <= '0;
      r_shadow <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_sclk   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_mosi   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          r_busy <= 1'b0;
          r_cnt  <= '0;
          // busy is still high during the done cycle, which blocks a same-cycle restart
          if (host.start && !r_busy) begin
            if (host.spi_mode == 2'b00) begin
              r_err <= 1'b1;
            end else begin
              r_frame <= w_frame_in;
              r_lanes <= w_lanes_in;
              r_write <= host.status_in[2];
              r_bit   <= '0;
              r_busy  <= 1'b1;
              r_cs_n  <= 1'b0;
              r_mosi  <= slot_bits(w_frame_in, 6'd0, w_lanes_in);
              r_state <= S_SETUP;
            end
          end
        end

        S_SETUP: begin
          if (r_cnt == LP_PHASE_LAST) begin
            r_cnt   <= '0;
            r_sclk  <= 1'b1;
            r_state <= S_SHIFT_HI;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        S_SHIFT_HI: begin
          if (r_cnt == LP_PHASE_LAST) begin
            if (!r_write && (r_bit >= 6'd32)) begin
              r_shadow <= w_shadow_nxt;
            end
            r_cnt   <= '0;
            r_sclk  <= 1'b0;
            r_bit   <= w_bit_nxt;
            r_state <= S_SHIFT_LO;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        S_SHIFT_LO: begin
          // mosi moves one clock after sclk falls so it is stable across the slave's sample edge
          if (r_cnt == 9'd0) begin
            r_mosi <= (r_bit >= 6'd48) ? 4'h0 : slot_bits(r_frame, r_bit, r_lanes);
          end
          if (r_cnt == LP_PHASE_LAST) begin
            r_cnt <= '0;
            if (r_bit >= 6'd48) begin
              r_state <= S_HOLD;
            end else begin
              r_sclk  <= 1'b1;
              r_state <= S_SHIFT_HI;
            end
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        S_HOLD: begin
          r_sclk <= 1'b0;
          r_mosi <= 4'h0;
          if (r_cnt == LP_PHASE_LAST) begin
            r_cnt  <= '0;
            r_cs_n <= 1'b1;
            if (!r_write) begin
              r_rdata <= r_shadow;
            end
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        S_GAP: begin
          if (r_cnt == LP_GAP_LAST) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_sclk  <= 1'b0;
          r_cs_n  <= 1'b1;
          r_mosi  <= 4'h0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sclk           = r_sclk;
  assign cs_n           = r_cs_n;
  assign mosi           = r_mosi;
  assign host.busy      = r_busy;
  assign host.done      = r_done;
  assign host.err       = r_err;
  assign host.rdata_out = r_rdata;

endmodule
